md_sequencer: RTL

//  Iterative multiply/divide unit with HI/LO registers and its control sequencer.

---
 rtl/md_sequencer_if.sv | 29 ++
 rtl/md_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: execute-stage bundle between the pipeline and the
// multiply/divide sequencer. The master modport is the pipeline side (decoded
// control bits and ALU operands); the slave modport is the md_sequencer side.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             mdstart;
  logic             signedop;
  logic             muldivb;
  logic             mthi;
  logic             mtlo;
  logic             hiloread;
  logic             hilosel;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] hilorddata;
  logic             mdbusy;
  logic             mdstall;

  modport master (
    output mdstart, signedop, muldivb, mthi, mtlo, hiloread, hilosel, srca, srcb,
    input  hilorddata, mdbusy, mdstall
  );

  modport slave (
    input  mdstart, signedop, muldivb, mthi, mtlo, hiloread, hilosel, srca, srcb,
    output hilorddata, mdbusy, mdstall
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU use shift-and-add, DIV/DIVU use restoring division; both retire
// one bit per cycle on unsigned magnitudes and fix the signs in a final cycle.
// MFHI/MFLO read combinationally, MTHI/MTLO write when idle, and the unit
// stalls the pipeline for any md instruction issued while it is busy.
// Optional feature macro: MD_EARLY_OUT_EN -- a multiply leaves RUN as soon as
// the remaining multiplier bits are all zero.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  md
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q,   state_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  // Multiply: running product. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  // Multiplicand, shifted left one place per iteration.
  logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
  // Multiply: remaining multiplier bits. Divide: divisor magnitude.
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [WIDTH-1:0]     hi_q,      hi_d;
  logic [WIDTH-1:0]     lo_q,      lo_d;
  logic                 is_mul_q,  is_mul_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;

  // Operand magnitudes and signs, taken straight from the bus at start.
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;

  // One iteration of each datapath, and the sign-fixed results.
  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_sub;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   div_acc;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 busy;

  // Operand capture: negate only signed negative inputs.
  always_comb begin
    a_neg = md.signedop & md.srca[WIDTH-1];
    b_neg = md.signedop & md.srcb[WIDTH-1];
    abs_a = a_neg ? -md.srca : md.srca;
    abs_b = b_neg ? -md.srcb : md.srcb;
  end

  // Single-step datapaths for RUN and the sign fix-up for FIX.
  always_comb begin
    mul_acc  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, mplier_q});
    // The true difference is below the divisor, so WIDTH bits suffice.
    rem_sub  = rem_sh[WIDTH-1:0] - mplier_q;
    div_acc  = rem_ge ? {rem_sub,           acc_q[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_mul_d  = is_mul_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      IDLE: begin
        if (md.mdstart) begin
          // A start takes priority; a coincident MT write is dropped.
          state_d   = RUN;
          cnt_d     = '0;
          is_mul_d  = md.muldivb;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          mplier_d  = abs_b;
          if (md.muldivb) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, abs_a};
          end else begin
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            mcand_d = '0;
          end
        end else begin
          if (md.mthi) hi_d = md.srca;
          if (md.mtlo) lo_d = md.srca;
        end
      end

      RUN: begin
        if (is_mul_q) begin
          acc_d    = mul_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          acc_d    = div_acc;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
`ifdef MD_EARLY_OUT_EN
        // No multiplier bits left after this step: the product is final.
        if (is_mul_q && ((mplier_q >> 1) == '0)) state_d = FIX;
`else
`endif
      end

      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (is_mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_mul_q  <= is_mul_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Status and read port back to the pipeline.
  always_comb begin
    busy          = (state_q != IDLE);
    md.mdbusy     = busy;
    md.mdstall    = busy & (md.mdstart | md.mthi | md.mtlo | md.hiloread);
    md.hilorddata = md.hilosel ? lo_q : hi_q;
  end

endmodule
